// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared register-file definitions: default geometry and the hard-wired zero register.
package regfile_mp_scoreboard_pkg;
   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int NR_DEF   = 2;
   localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Decode-side read ports plus the W0/W1 write ports and scoreboard lock request.
interface regfile_mp_scoreboard_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
);
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             w0_en;
   logic [AW-1:0]    w0_addr;
   logic [DW-1:0]    w0_data;
   logic [31:0]      w0_pc;
   logic             w1_en;
   logic [AW-1:0]    w1_addr;
   logic [DW-1:0]    w1_data;
   logic [31:0]      w1_pc;
   logic             lock_en;
   logic [AW-1:0]    lock_addr;

   modport master (
      output rd_addr, w0_en, w0_addr, w0_data, w0_pc,
             w1_en, w1_addr, w1_data, w1_pc, lock_en, lock_addr,
      input  rd_data, rd_busy
   );
   modport slave (
      input  rd_addr, w0_en, w0_addr, w0_data, w0_pc,
             w1_en, w1_addr, w1_data, w1_pc, lock_en, lock_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_mp_scoreboard_read_port.sv
// One combinational read port: zero register, W0/W1 write-through bypass, busy qualification.
module regfile_read_port
   import regfile_mp_scoreboard_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          reset,
   input  logic [AW-1:0] addr,
   input  logic          w0_en,
   input  logic [AW-1:0] w0_addr,
   input  logic [DW-1:0] w0_data,
   input  logic          w1_en,
   input  logic [AW-1:0] w1_addr,
   input  logic [DW-1:0] w1_data,
   input  logic [DW-1:0] stored,
   input  logic          busy_bit,
   output logic [DW-1:0] data,
   output logic          busy
);
   logic is_zero, w0_hit, w1_hit;

   assign is_zero = (addr == AW'(REG_ZERO));
   assign w0_hit  = w0_en && (w0_addr == addr);
   assign w1_hit  = w1_en && (w1_addr == addr);

   // Priority order keeps the bypass equal to whatever the next edge stores.
   always_comb begin
      data = stored;
      if (reset || is_zero) data = '0;
      else if (w0_hit)      data = w0_data;
      else if (w1_hit)      data = w1_data;
   end

   // A result retiring this cycle is already on the bypass, so it does not stall.
   assign busy = busy_bit && !w1_hit && !is_zero && !reset;
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-through bypass and per-register W1 busy scoreboard.
// Optional macro REGFILE_TRACE_EN prints one line per landed write.
module regfile_mp_scoreboard
   import regfile_mp_scoreboard_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int NR = NR_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_mp_scoreboard_if.slave bus
);
   localparam int DEPTH = 1 << AW;

   if (NR < 1 || NR > 4) begin : g_bad_nr
      $error("regfile_mp_scoreboard: NR must be in 1..4");
   end

   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] busy, busy_nxt;
   logic             w0_land, w1_land;

   assign w0_land = bus.w0_en && (bus.w0_addr != AW'(REG_ZERO));
   // W1 loses to a same-address W0 in the same cycle.
   assign w1_land = bus.w1_en && (bus.w1_addr != AW'(REG_ZERO))
                    && !(w0_land && (bus.w0_addr == bus.w1_addr));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (w1_land) mem[bus.w1_addr] <= bus.w1_data;
         if (w0_land) mem[bus.w0_addr] <= bus.w0_data;
      end
   end

   // Lock is applied after the retire-clear so a new issue overrides a retiring result.
   always_comb begin
      busy_nxt = busy;
      if (bus.w1_en)   busy_nxt[bus.w1_addr]   = 1'b0;
      if (bus.lock_en) busy_nxt[bus.lock_addr] = 1'b1;
      busy_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          pbusy;

      assign addr = bus.rd_addr[k*AW +: AW];

      regfile_read_port #(.DW(DW), .AW(AW)) u_port (
         .reset    (reset),
         .addr     (addr),
         .w0_en    (bus.w0_en),
         .w0_addr  (bus.w0_addr),
         .w0_data  (bus.w0_data),
         .w1_en    (bus.w1_en),
         .w1_addr  (bus.w1_addr),
         .w1_data  (bus.w1_data),
         .stored   (mem[addr]),
         .busy_bit (busy[addr]),
         .data     (data),
         .busy     (pbusy)
      );

      assign bus.rd_data[k*DW +: DW] = data;
      assign bus.rd_busy[k]          = pbusy;
   end

`ifdef REGFILE_TRACE_EN
   always @(posedge clk) begin
      if (!reset) begin
         if (w0_land) $display("@%h: $%d <= %h", bus.w0_pc, bus.w0_addr, bus.w0_data);
         if (w1_land) $display("@%h: $%d <= %h", bus.w1_pc, bus.w1_addr, bus.w1_data);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^{bus.w0_pc, bus.w1_pc};
`endif
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomised and directed bench for regfile_mp_scoreboard against a reference register model.
module tb_regfile_mp_scoreboard;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [DW-1:0] model [32];
   bit            mbusy [32];

   regfile_mp_scoreboard_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

   regfile_mp_scoreboard #(.DW(DW), .AW(AW), .NR(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      if (reset || a == 0)                      return '0;
      if (bus.w0_en && bus.w0_addr == a)        return bus.w0_data;
      if (bus.w1_en && bus.w1_addr == a)        return bus.w1_data;
      return model[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (reset || a == 0) return 1'b0;
      if (bus.w1_en && bus.w1_addr == a) return 1'b0;
      return mbusy[a];
   endfunction

   function automatic logic [DW-1:0] port_data(input int k);
      return bus.rd_data[k*DW +: DW];
   endfunction

   task automatic idle();
      bus.w0_en = 0; bus.w0_addr = '0; bus.w0_data = '0; bus.w0_pc = '0;
      bus.w1_en = 0; bus.w1_addr = '0; bus.w1_data = '0; bus.w1_pc = '0;
      bus.lock_en = 0; bus.lock_addr = '0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   // Advance one clock; the model absorbs the writes/locks presented this cycle.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         if (bus.w1_en && bus.w1_addr != 0) model[bus.w1_addr] = bus.w1_data;
         if (bus.w0_en && bus.w0_addr != 0) model[bus.w0_addr] = bus.w0_data;
         if (bus.w1_en)   mbusy[bus.w1_addr]   = 0;
         if (bus.lock_en) mbusy[bus.lock_addr] = 1;
         mbusy[0] = 0;
      end
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         model[i] = '0;
         mbusy[i] = 0;
      end
   endtask

   task automatic test_reset();
      reset = 1;
      idle();
      set_rd(5'd3, 5'd0);
      bus.w0_en = 1; bus.w0_addr = 5'd3; bus.w0_data = 32'h1111_2222;
      bus.lock_en = 1; bus.lock_addr = 5'd3;
      #1;
      total++;
      if (port_data(0) !== 32'h0) begin
         bad++; $display("FAIL reset_bypass: got %h want %h", port_data(0), 32'h0);
      end
      total++;
      if (bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL reset_busy: got %b want 00", bus.rd_busy);
      end
      tick();
      idle();
      reset = 0;
      clear_model();
      #1;
      total++;
      if (port_data(0) !== 32'h0 || bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL reset_write_ignored: got %h/%b want 0/00", port_data(0), bus.rd_busy);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      bus.w0_en = 1; bus.w0_addr = 5'd5; bus.w0_data = 32'h1234;
      bus.lock_en = 1; bus.lock_addr = 5'd6;
      tick();
      idle();
      set_rd(5'd5, 5'd6);
      #1;
      total++;
      if (port_data(0) !== 32'h1234 || bus.rd_busy !== 2'b10) begin
         bad++; $display("FAIL pre_reset: got %h/%b want 00001234/10", port_data(0), bus.rd_busy);
      end
      reset = 1;
      #1;
      clear_model();
      total++;
      if (port_data(0) !== 32'h0 || bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL mid_reset: got %h/%b want 00000000/00", port_data(0), bus.rd_busy);
      end
      tick();
      reset = 0;
      #1;
      total++;
      if (port_data(0) !== 32'h0 || bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL post_reset: got %h/%b want 00000000/00", port_data(0), bus.rd_busy);
      end
   endtask

   task automatic test_write_through();
      idle();
      set_rd(5'd3, 5'd4);
      bus.w0_en = 1; bus.w0_addr = 5'd3; bus.w0_data = 32'hDEAD_BEEF;
      #1;
      total++;
      if (port_data(0) !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL wt_bypass: got %h want deadbeef", port_data(0));
      end
      tick();
      idle();
      #1;
      total++;
      if (port_data(0) !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL wt_stored: got %h want deadbeef", port_data(0));
      end
      // W1 bypass on the second port
      bus.w1_en = 1; bus.w1_addr = 5'd4; bus.w1_data = 32'hCAFE_0004;
      #1;
      total++;
      if (port_data(1) !== 32'hCAFE_0004) begin
         bad++; $display("FAIL w1_bypass: got %h want cafe0004", port_data(1));
      end
      tick();
      idle();
   endtask

   task automatic test_zero_reg();
      idle();
      set_rd(5'd0, 5'd0);
      bus.w0_en = 1; bus.w0_addr = 5'd0; bus.w0_data = 32'hFFFF_FFFF;
      bus.w1_en = 1; bus.w1_addr = 5'd0; bus.w1_data = 32'hFFFF_FFFF;
      bus.lock_en = 1; bus.lock_addr = 5'd0;
      #1;
      total++;
      if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL zero_bypass: got %h/%b want 0/00", bus.rd_data, bus.rd_busy);
      end
      tick();
      idle();
      #1;
      total++;
      if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL zero_stored: got %h/%b want 0/00", bus.rd_data, bus.rd_busy);
      end
   endtask

   task automatic test_collision();
      idle();
      bus.lock_en = 1; bus.lock_addr = 5'd7;
      tick();
      idle();
      set_rd(5'd7, 5'd1);
      bus.w0_en = 1; bus.w0_addr = 5'd7; bus.w0_data = 32'hA;
      bus.w1_en = 1; bus.w1_addr = 5'd7; bus.w1_data = 32'hB;
      #1;
      total++;
      if (port_data(0) !== 32'hA || bus.rd_busy[0] !== 1'b0) begin
         bad++; $display("FAIL coll_bypass: got %h/%b want 0000000a/0", port_data(0), bus.rd_busy[0]);
      end
      tick();
      idle();
      #1;
      total++;
      if (port_data(0) !== 32'hA || bus.rd_busy[0] !== 1'b0) begin
         bad++; $display("FAIL coll_stored: got %h/%b want 0000000a/0", port_data(0), bus.rd_busy[0]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      set_rd(5'd9, 5'd9);
      bus.lock_en = 1; bus.lock_addr = 5'd9;
      #1;
      total++;
      if (bus.rd_busy !== 2'b00) begin
         bad++; $display("FAIL sb_lock_same_cycle: got %b want 00", bus.rd_busy);
      end
      tick();
      idle();
      #1;
      total++;
      if (bus.rd_busy !== 2'b11) begin
         bad++; $display("FAIL sb_locked: got %b want 11", bus.rd_busy);
      end
      bus.w1_en = 1; bus.w1_addr = 5'd9; bus.w1_data = 32'h55;
      #1;
      total++;
      if (bus.rd_busy !== 2'b00 || port_data(1) !== 32'h55) begin
         bad++; $display("FAIL sb_retire: got %b/%h want 00/00000055", bus.rd_busy, port_data(1));
      end
      tick();
      idle();
      bus.lock_en = 1; bus.lock_addr = 5'd9;
      bus.w1_en = 1; bus.w1_addr = 5'd9; bus.w1_data = 32'h66;
      tick();
      idle();
      #1;
      total++;
      if (bus.rd_busy !== 2'b11 || port_data(0) !== 32'h66) begin
         bad++; $display("FAIL sb_set_wins: got %b/%h want 11/00000066", bus.rd_busy, port_data(0));
      end
      bus.lock_en = 1; bus.lock_addr = 5'd9;
      tick();
      idle();
      bus.w1_en = 1; bus.w1_addr = 5'd9; bus.w1_data = 32'h77;
      tick();
      idle();
      #1;
      total++;
      if (bus.rd_busy !== 2'b00 || port_data(0) !== 32'h77) begin
         bad++; $display("FAIL sb_double_lock: got %b/%h want 00/00000077", bus.rd_busy, port_data(0));
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 400; n++) begin
         idle();
         bus.rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         bus.w0_en     = 1'($urandom_range(0, 1));
         bus.w0_addr   = 5'($urandom_range(0, 7));
         bus.w0_data   = $urandom;
         bus.w0_pc     = $urandom;
         bus.w1_en     = 1'($urandom_range(0, 1));
         bus.w1_addr   = 5'($urandom_range(0, 7));
         bus.w1_data   = $urandom;
         bus.w1_pc     = $urandom;
         bus.lock_en   = 1'($urandom_range(0, 1));
         bus.lock_addr = 5'($urandom_range(0, 7));
         #1;
         for (int k = 0; k < NR; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            total++;
            if (port_data(k) !== exp_data(a) || bus.rd_busy[k] !== exp_busy(a)) begin
               bad++;
               $display("FAIL rand_port%0d n=%0d addr=%0d: got %h/%b want %h/%b",
                        k, n, a, port_data(k), bus.rd_busy[k], exp_data(a), exp_busy(a));
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      reset = 1;
      bus.rd_addr = '0;
      idle();
      clear_model();
      @(negedge clk);
      test_reset();
      test_reset_mid();
      test_write_through();
      test_zero_reg();
      test_collision();
      test_scoreboard();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
